// File: rtl/mem_access_if.sv
// Pipeline-to-memory bundle for mem_access_unit: request/response side
// plus the word-wide dataMemory port.
interface mem_access_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_err;
    logic [31:0]       resp_rdata;
    logic              mem_active;
    logic              mem_rw;
    logic [31:0]       mem_index;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    // Environment side: pipeline driving requests, memory returning data
    modport master (
        output req_valid,
        output req_write,
        output req_size,
        output req_unsigned,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  resp_valid,
        input  resp_err,
        input  resp_rdata,
        input  mem_active,
        input  mem_rw,
        input  mem_index,
        input  mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  req_valid,
        input  req_write,
        input  req_size,
        input  req_unsigned,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output resp_valid,
        output resp_err,
        output resp_rdata,
        output mem_active,
        output mem_rw,
        output mem_index,
        output mem_wdata,
        input  mem_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for the word-wide dataMemory port.
// Byte/half stores are carried out as read-modify-write on the full word.
module mem_access_unit #(
    parameter int MEM_LAT = 1,
    parameter int ADDR_W  = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    mem_access_if.slave bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          write_q, write_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic [1:0]    lane_q, lane_d;
    logic [15:0]   wdata_q, wdata_d;
    logic          ready_q, ready_d;
    logic          rv_q, rv_d;
    logic          re_q, re_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          act_q, act_d;
    logic          rw_q, rw_d;
    logic [31:0]   idx_q, idx_d;
    logic [31:0]   mwd_q, mwd_d;
    logic          req_bad;

    // Replace only the enabled byte lanes of the word just read
    function automatic logic [31:0] merge_word(
        input logic [31:0] old,
        input logic [15:0] wd,
        input logic [1:0]  sz,
        input logic [1:0]  lane
    );
        logic [31:0] rep;
        logic [3:0]  be;
        logic [31:0] res;
        rep = (sz == 2'b00) ? {4{wd[7:0]}} : {2{wd}};
        if (sz == 2'b00) begin
            be = 4'b0001 << lane;
        end else if (lane[1]) begin
            be = 4'b1100;
        end else begin
            be = 4'b0011;
        end
        for (int k = 0; k < 4; k++) begin
            res[8*k +: 8] = be[k] ? rep[8*k +: 8] : old[8*k +: 8];
        end
        return res;
    endfunction

    function automatic logic [31:0] load_ext(
        input logic [31:0] w,
        input logic [1:0]  sz,
        input logic [1:0]  lane,
        input logic        uns
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{lane, 3'b000} +: 8];
        h = w[{lane[1], 4'b0000} +: 16];
        unique case (1'b1)
            (sz == 2'b00): r = {{24{~uns & b[7]}}, b};
            (sz == 2'b01): r = {{16{~uns & h[15]}}, h};
            default:       r = w;
        endcase
        return r;
    endfunction

    always_comb begin
        req_bad = (bus.req_size == 2'b11)
               || (bus.req_size == 2'b01 && bus.req_addr[0])
               || (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        size_d  = size_q;
        uns_d   = uns_q;
        lane_d  = lane_q;
        wdata_d = wdata_q;
        ready_d = ready_q;
        rv_d    = rv_q;
        re_d    = re_q;
        rdata_d = rdata_q;
        act_d   = act_q;
        rw_d    = rw_q;
        idx_d   = idx_q;
        mwd_d   = mwd_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    write_d = bus.req_write;
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    lane_d  = bus.req_addr[1:0];
                    wdata_d = bus.req_wdata[15:0];
                    idx_d   = 32'(bus.req_addr >> 2);
                    cnt_d   = CW'(MEM_LAT - 1);
                    ready_d = 1'b0;
                    if (req_bad) begin
                        state_d = RESP;
                        rv_d    = 1'b1;
                        re_d    = 1'b1;
                        rdata_d = '0;
                    end else if (bus.req_write
                              && bus.req_size == 2'b10) begin
                        state_d = WR;
                        act_d   = 1'b1;
                        rw_d    = 1'b1;
                        mwd_d   = bus.req_wdata;
                    end else begin
                        state_d = RD;
                        act_d   = 1'b1;
                        rw_d    = 1'b0;
                    end
                end
            end
            RD: begin
                if (cnt_q == '0) begin
                    if (write_q) begin
                        // active stays high; only the direction flips
                        state_d = WR;
                        rw_d    = 1'b1;
                        mwd_d   = merge_word(bus.mem_rdata, wdata_q,
                                             size_q, lane_q);
                    end else begin
                        state_d = RESP;
                        act_d   = 1'b0;
                        rv_d    = 1'b1;
                        rdata_d = load_ext(bus.mem_rdata, size_q,
                                           lane_q, uns_q);
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WR: begin
                state_d = RESP;
                act_d   = 1'b0;
                rw_d    = 1'b0;
                rv_d    = 1'b1;
                re_d    = 1'b0;
                rdata_d = '0;
            end
            RESP: begin
                state_d = IDLE;
                rv_d    = 1'b0;
                re_d    = 1'b0;
                rdata_d = '0;
                ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            lane_q  <= 2'b00;
            wdata_q <= '0;
            ready_q <= 1'b1;
            rv_q    <= 1'b0;
            re_q    <= 1'b0;
            rdata_q <= '0;
            act_q   <= 1'b0;
            rw_q    <= 1'b0;
            idx_q   <= '0;
            mwd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            lane_q  <= lane_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            rv_q    <= rv_d;
            re_q    <= re_d;
            rdata_q <= rdata_d;
            act_q   <= act_d;
            rw_q    <= rw_d;
            idx_q   <= idx_d;
            mwd_q   <= mwd_d;
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = rv_q;
    assign bus.resp_err   = re_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.mem_active = act_q;
    assign bus.mem_rw     = rw_q;
    assign bus.mem_index  = idx_q;
    assign bus.mem_wdata  = mwd_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: two instances (MEM_LAT 1 and 3) share the
// request stream and are compared cycle by cycle with a reference model.
module tb_mem_access_unit;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    mem_access_if #(.ADDR_W(32)) b1 ();
    mem_access_if #(.ADDR_W(32)) b3 ();

    mem_access_unit #(.MEM_LAT(1), .ADDR_W(32)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    mem_access_unit #(.MEM_LAT(3), .ADDR_W(32)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b3)
    );

    logic [31:0] mem1 [16];
    logic [31:0] mem3 [16];
    logic [31:0] refm [16];

    assign b1.mem_rdata = mem1[b1.mem_index[3:0]];
    assign b3.mem_rdata = mem3[b3.mem_index[3:0]];

    always @(posedge clk) begin
        if (b1.mem_active && b1.mem_rw && b1.mem_index < 16)
            mem1[b1.mem_index[3:0]] <= b1.mem_wdata;
        if (b3.mem_active && b3.mem_rw && b3.mem_index < 16)
            mem3[b3.mem_index[3:0]] <= b3.mem_wdata;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          nacc;
        int          resp;
        bit          err;
        logic [31:0] wd;
        logic [31:0] rd;
    } exp_t;

    typedef struct {
        logic        rdy, rv, re, act, rw;
        logic [31:0] rd, idx, wd;
    } obs_t;

    function automatic exp_t model(input int lat, input bit w,
                                   input logic [1:0] sz, input bit u,
                                   input logic [5:0] a,
                                   input logic [31:0] wd,
                                   input logic [31:0] old);
        exp_t        e;
        int          sh;
        logic [31:0] m;
        logic [31:0] v;
        e.err = (sz == 3) || (sz == 1 && a % 2 != 0)
             || (sz == 2 && a % 4 != 0);
        sh = (sz == 0) ? 8 * (a % 4) : 16 * ((a / 2) % 2);
        m  = (sz == 0) ? 32'hFF : (sz == 1) ? 32'hFFFF : 32'hFFFF_FFFF;
        e.wd = 0;
        e.rd = 0;
        if (e.err) begin
            e.nacc = 0;
            e.resp = 1;
        end else if (!w) begin
            e.nacc = lat;
            e.resp = lat + 1;
            v = (old >> sh) & m;
            if (!u && sz != 2 && (v & ((m + 1) >> 1)) != 0)
                v = v | ~m;
            e.rd = v;
        end else if (sz == 2) begin
            e.nacc = 1;
            e.resp = 2;
            e.wd   = wd;
        end else begin
            e.nacc = lat + 1;
            e.resp = lat + 2;
            e.wd   = (old & ~(m << sh)) | ((wd & m) << sh);
        end
        return e;
    endfunction

    function automatic obs_t get(input int i);
        obs_t o;
        if (i == 1) begin
            o.rdy = b1.req_ready;  o.rv  = b1.resp_valid;
            o.re  = b1.resp_err;   o.rd  = b1.resp_rdata;
            o.act = b1.mem_active; o.rw  = b1.mem_rw;
            o.idx = b1.mem_index;  o.wd  = b1.mem_wdata;
        end else begin
            o.rdy = b3.req_ready;  o.rv  = b3.resp_valid;
            o.re  = b3.resp_err;   o.rd  = b3.resp_rdata;
            o.act = b3.mem_active; o.rw  = b3.mem_rw;
            o.idx = b3.mem_index;  o.wd  = b3.mem_wdata;
        end
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] o,
                       input logic [31:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic chk_reset(input string tag, input obs_t o);
        chk({tag, ".rst.rdy"}, 32'(o.rdy), 32'd1);
        chk({tag, ".rst.rv"},  32'(o.rv),  32'd0);
        chk({tag, ".rst.re"},  32'(o.re),  32'd0);
        chk({tag, ".rst.rd"},  o.rd,       32'd0);
        chk({tag, ".rst.act"}, 32'(o.act), 32'd0);
        chk({tag, ".rst.rw"},  32'(o.rw),  32'd0);
        chk({tag, ".rst.idx"}, o.idx,      32'd0);
        chk({tag, ".rst.wd"},  o.wd,       32'd0);
    endtask

    task automatic chk_cyc(input string tag, input obs_t o, input exp_t e,
                           input int k, input logic [5:0] a, input bit w);
        string t;
        bool_t: begin end
        t = $sformatf("%s.c%0d", tag, k);
        chk({t, ".rdy"}, 32'(o.rdy), 32'(k > e.resp));
        chk({t, ".rv"},  32'(o.rv),  32'(k == e.resp));
        chk({t, ".act"}, 32'(o.act), 32'(!e.err && k <= e.nacc));
        chk({t, ".rw"},  32'(o.rw),  32'(w && !e.err && k == e.nacc));
        if (k == e.resp) begin
            chk({t, ".err"}, 32'(o.re), 32'(e.err));
            chk({t, ".rdata"}, o.rd, e.rd);
        end
        if (!e.err && k <= e.nacc)
            chk({t, ".idx"}, o.idx, 32'(a / 4));
        if (w && !e.err && k == e.nacc)
            chk({t, ".wdata"}, o.wd, e.wd);
    endtask

    task automatic drive(input bit w, input logic [1:0] sz, input bit u,
                         input logic [5:0] a, input logic [31:0] wd);
        b1.req_write = w;  b3.req_write = w;
        b1.req_size = sz;  b3.req_size = sz;
        b1.req_unsigned = u;  b3.req_unsigned = u;
        b1.req_addr = 32'(a);  b3.req_addr = 32'(a);
        b1.req_wdata = wd;  b3.req_wdata = wd;
    endtask

    task automatic run(input bit w, input logic [1:0] sz, input bit u,
                       input logic [5:0] a, input logic [31:0] wd,
                       input bit hold3);
        exp_t e1;
        exp_t e3;
        int   last;
        e1 = model(1, w, sz, u, a, wd, refm[a[5:2]]);
        e3 = model(3, w, sz, u, a, wd, refm[a[5:2]]);
        last = ((e1.resp > e3.resp) ? e1.resp : e3.resp) + 1;
        @(negedge clk);
        drive(w, sz, u, a, wd);
        b1.req_valid = 1'b1;
        b3.req_valid = 1'b1;
        @(negedge clk);
        b1.req_valid = 1'b0;
        b3.req_valid = hold3;
        for (int k = 1; k <= last; k++) begin
            if (k <= e1.resp + 1) chk_cyc("L1", get(1), e1, k, a, w);
            if (k <= e3.resp + 1) chk_cyc("L3", get(3), e3, k, a, w);
            if (k < last) @(negedge clk);
        end
        if (w && !e1.err) begin
            refm[a[5:2]] = e1.wd;
            chk($sformatf("L1.mem%0d", a[5:2]), mem1[a[5:2]], refm[a[5:2]]);
            chk($sformatf("L3.mem%0d", a[5:2]), mem3[a[5:2]], refm[a[5:2]]);
        end
    endtask

    initial begin
        int c;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        b1.req_valid = 1'b0;
        b3.req_valid = 1'b0;
        drive(1'b0, 2'b00, 1'b0, 6'd0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk_reset("L1", get(1));
        chk_reset("L3", get(3));
        rst_n = 1'b1;

        run(1'b1, 2'b10, 1'b0, 6'd4, 32'h0000_0004, 1'b0);
        chk("plan.mem1", mem1[1], 32'h0000_0004);
        for (int i = 0; i < 16; i++)
            run(1'b1, 2'b10, 1'b0, 6'(4 * i), $urandom, 1'b0);

        run(1'b1, 2'b10, 1'b0, 6'd4, 32'h8040_2010, 1'b0);
        run(1'b0, 2'b00, 1'b0, 6'd7, 32'd0, 1'b0);
        run(1'b0, 2'b00, 1'b1, 6'd7, 32'd0, 1'b0);
        run(1'b0, 2'b00, 1'b0, 6'd5, 32'd0, 1'b0);
        run(1'b0, 2'b01, 1'b0, 6'd6, 32'd0, 1'b0);
        run(1'b1, 2'b01, 1'b0, 6'd6, 32'h1234_BEEF, 1'b0);
        chk("plan.half_store", mem1[1], 32'hBEEF_2010);

        run(1'b0, 2'b10, 1'b0, 6'd5, 32'd0, 1'b0);
        run(1'b0, 2'b11, 1'b0, 6'd8, 32'd0, 1'b0);
        run(1'b1, 2'b01, 1'b0, 6'd3, 32'hFFFF_FFFF, 1'b0);

        // Abort a half store while it is still reading
        @(negedge clk);
        drive(1'b1, 2'b01, 1'b0, 6'd6, 32'h0000_5A5A);
        b1.req_valid = 1'b1;
        b3.req_valid = 1'b1;
        @(negedge clk);
        b1.req_valid = 1'b0;
        b3.req_valid = 1'b0;
        chk("abort.L1.act_pre", 32'(b1.mem_active), 32'd1);
        chk("abort.L3.act_pre", 32'(b3.mem_active), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort.L1.act", 32'(b1.mem_active), 32'd0);
        chk("abort.L3.act", 32'(b3.mem_active), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 1) rst_n = 1'b1;
            chk($sformatf("abort.L1.rv%0d", i), 32'(b1.resp_valid), 32'd0);
            chk($sformatf("abort.L3.rv%0d", i), 32'(b3.resp_valid), 32'd0);
        end
        chk("abort.L1.rdy", 32'(b1.req_ready), 32'd1);
        chk("abort.L3.rdy", 32'(b3.req_ready), 32'd1);
        chk("abort.L1.mem1", mem1[1], refm[1]);
        chk("abort.L3.mem1", mem3[1], refm[1]);

        for (int i = 0; i < 40; i++)
            run(1'($urandom), 2'($urandom), 1'($urandom),
                6'($urandom), $urandom, 1'b0);

        // Second load held on the LAT3 instance through the first one
        run(1'b0, 2'b10, 1'b0, 6'd8, 32'd0, 1'b1);
        @(negedge clk);
        chk("hold.rdy", 32'(b3.req_ready), 32'd0);
        chk("hold.act", 32'(b3.mem_active), 32'd1);
        chk("hold.idx", b3.mem_index, 32'd2);
        b3.req_valid = 1'b0;
        c = 6;
        while (c < 20 && !b3.resp_valid) begin
            @(negedge clk);
            c++;
        end
        chk("hold.resp_cycle", 32'(c), 32'd9);
        chk("hold.rdata", b3.resp_rdata, refm[2]);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
